pkt_fifo_param: RTL and testbench

// - Parametrised packet-aware FIFO for the 1x3 router output channels; one instance per destination port.
// - Stores each byte together with its lfd (header) tag. Tracks the length of the packet being read out.
// - Adds occupancy count, write-overflow indication and an end-of-packet pulse over the fixed 8x16 FIFO.
//

---
 rtl/pkt_fifo_pkg.sv | 33 +++
 rtl/pkt_fifo_mem.sv | 23 ++
 rtl/pkt_fifo_param.sv | 112 +++++++++++
 tb/tb_pkt_fifo_param.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared sizing helpers and header decode for the packet-aware output FIFO.
// The almost_full watermark is enabled in the top by defining PKT_FIFO_WATERMARK_EN.
package pkt_fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_LEN_W  = 6;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int word_w(input int data_w);
      return data_w + 1;
   endfunction

   // The lfd tag sits directly above the payload byte in a stored word.
   function automatic int tag_bit(input int data_w);
      return data_w;
   endfunction

   function automatic int unsigned hdr_len(input logic [31:0] word, input int data_w,
                                           input int len_w);
      logic [31:0] mask;
      mask = (32'd1 << len_w) - 32'd1;
      return (word >> (data_w - len_w)) & mask;
   endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Storage array for the packet FIFO: one write port, one asynchronous read port, no reset.
module pkt_fifo_mem #(
   parameter int WORD_W = 9,
   parameter int DEPTH  = 16,
   parameter int PTR_W  = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [PTR_W-1:0]  waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [PTR_W-1:0]  raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_fifo_param.sv
// Packet-aware output FIFO: tagged storage, occupancy, overflow pulse and end-of-packet pulse.
// Define PKT_FIFO_WATERMARK_EN to add the registered almost_full output (threshold AF_LVL).
module pkt_fifo_param
   import pkt_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int LEN_W  = DEF_LEN_W
`ifdef PKT_FIFO_WATERMARK_EN
   ,parameter int AF_LVL = DEPTH - 2
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   soft_rst,
   input  logic                   we,
   input  logic                   lfd,
   input  logic [DATA_W-1:0]      din,
   input  logic                   re,
   output logic [DATA_W-1:0]      dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   wr_err,
   output logic                   pkt_done
`ifdef PKT_FIFO_WATERMARK_EN
   ,output logic                  almost_full
`endif
);

   localparam int PTR_W  = ptr_w(DEPTH);
   localparam int CNT_W  = cnt_w(DEPTH);
   localparam int WORD_W = word_w(DATA_W);
   localparam int TAG    = tag_bit(DATA_W);

   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count_nxt;
   logic [WORD_W-1:0] rd_word;
   logic [LEN_W:0]    rd_len, len_load;
   logic              wr_ok, rd_ok, mem_we;

   // Full blocks the write even when a read frees a slot the same cycle.
   assign wr_ok     = we && !full;
   assign rd_ok     = re && !empty;
   assign mem_we    = wr_ok && !soft_rst && !rst;
   assign count_nxt = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
   assign len_load  = (LEN_W+1)'(hdr_len(32'(rd_word), DATA_W, LEN_W) + 1);

   pkt_fifo_mem #(
      .WORD_W(WORD_W),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .waddr(wr_ptr),
      .wdata({lfd, din}),
      .raddr(rd_ptr),
      .rdata(rd_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         rd_len   <= '0;
         dout     <= '0;
         wr_err   <= 1'b0;
         pkt_done <= 1'b0;
      end else if (soft_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         rd_len   <= '0;
         dout     <= '0;
         wr_err   <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
         count    <= count_nxt;
         empty    <= (count_nxt == '0);
         full     <= (count_nxt == CNT_W'(DEPTH));
         wr_err   <= we && full;
         pkt_done <= 1'b0;
         if (rd_ok) begin
            dout <= rd_word[DATA_W-1:0];
            // A header always reloads, so a truncated packet never reaches 1 -> 0.
            if (rd_word[TAG]) begin
               rd_len <= len_load;
            end else if (rd_len != '0) begin
               rd_len   <= rd_len - (LEN_W+1)'(1);
               pkt_done <= (rd_len == (LEN_W+1)'(1));
            end
         end
      end
   end

`ifdef PKT_FIFO_WATERMARK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           almost_full <= 1'b0;
      else if (soft_rst) almost_full <= 1'b0;
      else               almost_full <= (count_nxt >= CNT_W'(AF_LVL));
   end
`endif

endmodule

// File: tb/tb_pkt_fifo_param.sv
// Directed bench for pkt_fifo_param (default 8-bit x 16 configuration).
module tb_pkt_fifo_param;

   logic       clk = 1'b0;
   logic       rst, soft_rst, we, lfd, re;
   logic [7:0] din, dout;
   logic       empty, full, wr_err, pkt_done;
   logic [4:0] count;
`ifdef PKT_FIFO_WATERMARK_EN
   logic       almost_full;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] pkt [16];
   logic [7:0] par;

   always #5 clk = ~clk;

   pkt_fifo_param #(
      .DATA_W(8),
      .DEPTH (16),
      .LEN_W (6)
`ifdef PKT_FIFO_WATERMARK_EN
      ,.AF_LVL(14)
`endif
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .soft_rst(soft_rst),
      .we      (we),
      .lfd     (lfd),
      .din     (din),
      .re      (re),
      .dout    (dout),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .wr_err  (wr_err),
      .pkt_done(pkt_done)
`ifdef PKT_FIFO_WATERMARK_EN
      ,.almost_full(almost_full)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_pkt_b();
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; lfd = (i == 0); din = pkt[i];
         step();
      end
      we = 1'b0; lfd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; soft_rst = 1'b0; we = 1'b0; lfd = 1'b0; re = 1'b0; din = '0;
      // Header 8'h39 -> length 14; payload 01..0E; parity is xor of all prior bytes.
      pkt[0] = 8'h39;
      par = 8'h39;
      for (int i = 1; i < 15; i++) begin
         pkt[i] = 8'(i);
         par = par ^ 8'(i);
      end
      pkt[15] = par;

      step(); step();
      rst = 1'b0;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_dout", 32'(dout), 0);
      check("rst_wr_err", 32'(wr_err), 0);
      check("rst_pkt_done", 32'(pkt_done), 0);

      // Full 16-word packet in, then out in order.
      write_pkt_b();
      check("pkt_full", 32'(full), 1);
      check("pkt_count16", 32'(count), 16);
      check("pkt_no_wr_err", 32'(wr_err), 0);
      for (int i = 0; i < 16; i++) begin
         re = 1'b1;
         step();
         check($sformatf("pkt_dout%0d", i), 32'(dout), 32'(pkt[i]));
         check($sformatf("pkt_done%0d", i), 32'(pkt_done), (i == 15) ? 1 : 0);
      end
      re = 1'b0;
      check("pkt_empty_after", 32'(empty), 1);
      check("pkt_count0", 32'(count), 0);
      step();
      check("pkt_done_drops", 32'(pkt_done), 0);

      // 17 writes: the 17th overflows.
      for (int i = 0; i < 17; i++) begin
         we = 1'b1; din = 8'h40 + 8'(i);
         step();
         if (i == 15) check("ovf_full16", 32'(full), 1);
         if (i == 14) check("ovf_not_full15", 32'(full), 0);
      end
      check("ovf_wr_err", 32'(wr_err), 1);
      check("ovf_count", 32'(count), 16);
      we = 1'b0;
      step();
      check("ovf_wr_err_pulse", 32'(wr_err), 0);

      // Full with we=re=1: read proceeds, write dropped.
      we = 1'b1; re = 1'b1; din = 8'hAA;
      step();
      check("fullrw_wr_err", 32'(wr_err), 1);
      check("fullrw_count", 32'(count), 15);
      check("fullrw_dout", 32'(dout), 32'h40);
      we = 1'b0;
      for (int i = 1; i < 16; i++) begin
         step();
         check($sformatf("ovf_dout%0d", i), 32'(dout), 32'h40 + i);
         check($sformatf("ovf_nodone%0d", i), 32'(pkt_done), 0);
      end
      re = 1'b0;
      check("ovf_empty", 32'(empty), 1);

      // Empty with we=re=1: write only, dout holds.
      we = 1'b1; re = 1'b1; din = 8'h77;
      step();
      we = 1'b0; re = 1'b0;
      check("emptyrw_count", 32'(count), 1);
      check("emptyrw_dout", 32'(dout), 32'h4F);
      check("emptyrw_empty", 32'(empty), 0);
      re = 1'b1;
      step();
      re = 1'b0;
      check("emptyrw_read", 32'(dout), 32'h77);
      check("emptyrw_empty2", 32'(empty), 1);

      // soft_rst after reading 5 of 16 words.
      write_pkt_b();
      re = 1'b1;
      for (int i = 0; i < 5; i++) step();
      re = 1'b0;
      check("sr_dout4", 32'(dout), 32'(pkt[4]));
      check("sr_count11", 32'(count), 11);
      soft_rst = 1'b1;
      step();
      soft_rst = 1'b0;
      check("sr_count", 32'(count), 0);
      check("sr_empty", 32'(empty), 1);
      check("sr_dout", 32'(dout), 0);
      check("sr_rd_len", 32'(dut.rd_len), 0);
      // Header 8'h09 -> length 2; parity 09^A1^A2 = 0A.
      we = 1'b1; lfd = 1'b1; din = 8'h09; step();
      lfd = 1'b0; din = 8'hA1; step();
      din = 8'hA2; step();
      din = 8'h0A; step();
      we = 1'b0;
      re = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("sr_pkt_done%0d", i), 32'(pkt_done), (i == 3) ? 1 : 0);
      end
      re = 1'b0;
      check("sr_parity", 32'(dout), 32'h0A);

      // rst mid-packet aborts without pkt_done.
      we = 1'b1; lfd = 1'b1; din = 8'h09; step();
      lfd = 1'b0; din = 8'hB1; step();
      we = 1'b0; re = 1'b1; step();
      check("mid_hdr_dout", 32'(dout), 32'h09);
      #2 rst = 1'b1;
      step();
      check("mid_count", 32'(count), 0);
      check("mid_empty", 32'(empty), 1);
      check("mid_full", 32'(full), 0);
      check("mid_dout", 32'(dout), 0);
      check("mid_pkt_done", 32'(pkt_done), 0);
      rst = 1'b0; re = 1'b0;
      step();
      check("mid_pkt_done2", 32'(pkt_done), 0);

`ifdef PKT_FIFO_WATERMARK_EN
      for (int i = 0; i < 14; i++) begin
         we = 1'b1; din = 8'(i);
         step();
         if (i == 12) check("af_low13", 32'(almost_full), 0);
      end
      we = 1'b0;
      check("af_high14", 32'(almost_full), 1);
      re = 1'b1;
      step();
      re = 1'b0;
      check("af_count13", 32'(count), 13);
      check("af_fall13", 32'(almost_full), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
